// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and mode constants for decoder_nx_seq
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, GAP} state_e;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: enabled code -> one-hot decoder built as a tree of 2-to-4 leaves
module onehot_dec #(
  parameter int N = 3
) (
  input  logic            en_i,
  input  logic [N-1:0]    sel_i,
  output logic [2**N-1:0] y_o
);
  localparam int P   = N / 2;
  localparam int ODD = N % 2;
  localparam int R   = 1 << ODD;
  logic [R-1:0] root;
  if (ODD == 1) begin : g_odd
    assign root = {en_i & sel_i[N-1], en_i & ~sel_i[N-1]};
  end else begin : g_even
    assign root = en_i;
  end
  for (genvar i = 0; i < P; i++) begin : g_l
    localparam int W = R << (2 * i);
    logic [W-1:0]   e;
    logic [4*W-1:0] o;
    if (i == 0) begin : g_first
      assign e = root;
    end else begin : g_next
      assign e = g_l[i-1].o;
    end
    for (genvar j = 0; j < W; j++) begin : g_j
      assign o[4*j +: 4] = {4{e[j]}} & (4'b1 << sel_i[2*(P-1-i) +: 2]);
    end
  end
  if (P == 0) begin : g_leaf
    assign y_o = root;
  end else begin : g_tree
    assign y_o = g_l[P-1].o;
  end
endmodule

// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered one-hot decoder with handshake DIRECT mode and dwell-timed SCAN mode
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DW      = 8,
  parameter bit ACT_LOW = 1'b0,
  parameter bit BBM     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_sel,
  input  logic [DW-1:0]   dwell,
  output logic [2**N-1:0] y,
  output logic            y_valid,
  output logic [N-1:0]    cur_sel,
  output logic            wrap
);
  localparam int M = 2 ** N;
  state_e        state_q, state_d;
  logic [N-1:0]  cur_q, cur_d, pend_q, pend_d, nxt;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d, wrap_q, wrap_d, ret_q, ret_d;
  logic [M-1:0]  y_q, y_d, oh;
  assign nxt      = cur_q + 1'b1;
  assign in_ready = state_q == DIRECT;
  // next state: mode/enable changes drop to IDLE first; GAP holds the pending code for one off cycle
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ret_d   = ret_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        val_d = 1'b0;
        if (en && mode == MODE_SCAN) begin
          state_d = SCAN;
          cur_d   = '0;
          cnt_d   = '0;
          val_d   = 1'b1;
        end else if (en) state_d = DIRECT;
      end
      DIRECT: begin
        if (!en || mode == MODE_SCAN) begin
          state_d = IDLE;
          val_d   = 1'b0;
        end else if (in_valid && !(val_q && in_sel == cur_q)) begin
          if (BBM && val_q) begin
            state_d = GAP;
            pend_d  = in_sel;
            ret_d   = MODE_DIRECT;
            val_d   = 1'b0;
          end else begin
            cur_d = in_sel;
            val_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (!en || mode == MODE_DIRECT) begin
          state_d = IDLE;
          val_d   = 1'b0;
        end else if (cnt_q == dwell) begin
          cnt_d = '0;
          if (BBM) begin
            state_d = GAP;
            pend_d  = nxt;
            ret_d   = MODE_SCAN;
            val_d   = 1'b0;
          end else begin
            cur_d  = nxt;
            wrap_d = nxt == '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: begin
        if (!en || mode != ret_q) begin
          state_d = IDLE;
          val_d   = 1'b0;
        end else begin
          state_d = ret_q == MODE_SCAN ? SCAN : DIRECT;
          cur_d   = pend_q;
          cnt_d   = '0;
          val_d   = 1'b1;
          wrap_d  = ret_q == MODE_SCAN && pend_q == '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  onehot_dec #(.N(N)) u_dec (
    .en_i (val_d),
    .sel_i(cur_d),
    .y_o  (oh)
  );
  assign y_d = oh ^ {M{ACT_LOW}};
  // state and output registers, output polarity already applied in y_d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      ret_q   <= MODE_DIRECT;
      wrap_q  <= 1'b0;
      y_q     <= {M{ACT_LOW}};
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ret_q   <= ret_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end
  assign y       = y_q;
  assign y_valid = val_q;
  assign cur_sel = cur_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_nx_seq.sv
// tb_decoder_nx_seq: vector table, corner sequences and random run against a behavioural model
module tb_decoder_nx_seq;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, iv = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] dw = '0;
  logic [7:0] y0, y1;
  logic       v0, v1, r0, r1, w0, w1;
  logic [2:0] c0, c1;
  int checks = 0, fails = 0;
  int eng[2], code[2], on[2], elapsed[2], blank[2], wr[2];

  typedef struct {
    bit e, m, v;
    logic [2:0] s;
    logic [7:0] d, y;
    bit val, rdy;
    logic [2:0] cs;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  decoder_nx_seq #(.N(3), .DW(8), .ACT_LOW(1'b0), .BBM(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(iv), .in_ready(r0),
    .in_sel(sel), .dwell(dw), .y(y0), .y_valid(v0), .cur_sel(c0), .wrap(w0));
  decoder_nx_seq #(.N(3), .DW(8), .ACT_LOW(1'b1), .BBM(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(iv), .in_ready(r1),
    .in_sel(sel), .dwell(dw), .y(y1), .y_valid(v1), .cur_sel(c1), .wrap(w1));

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      eng[i] = -1; code[i] = 0; on[i] = 0; elapsed[i] = 0; blank[i] = -1; wr[i] = 0;
    end
  endtask

  // instance 1 is the break-before-make one; eng: -1 disengaged, 0 direct, 1 scan
  task automatic mstep(int i);
    wr[i] = 0;
    if (!en || (eng[i] >= 0 && int'(mode) != eng[i])) begin
      eng[i] = -1; on[i] = 0; blank[i] = -1;
    end else if (eng[i] < 0) begin
      eng[i] = int'(mode);
      on[i] = int'(mode);
      if (mode) begin code[i] = 0; elapsed[i] = 0; end
    end else if (blank[i] >= 0) begin
      code[i] = blank[i]; blank[i] = -1; on[i] = 1; elapsed[i] = 0;
      wr[i] = int'(eng[i] == 1 && code[i] == 0);
    end else if (eng[i] == 0) begin
      if (iv && !(on[i] != 0 && int'(sel) == code[i])) begin
        if (i == 1 && on[i] != 0) begin blank[i] = int'(sel); on[i] = 0; end
        else begin code[i] = int'(sel); on[i] = 1; end
      end
    end else if (elapsed[i] == int'(dw)) begin
      elapsed[i] = 0;
      if (i == 1) begin blank[i] = (code[i] + 1) % 8; on[i] = 0; end
      else begin code[i] = (code[i] + 1) % 8; on[i] = 1; wr[i] = int'(code[i] == 0); end
    end else elapsed[i]++;
  endtask

  function automatic logic [7:0] ey(int i);
    logic [7:0] v;
    v = on[i] != 0 ? 8'(1 << code[i]) : 8'h00;
    return i == 1 ? ~v : v;
  endfunction

  task automatic cyc(bit e, bit m, bit v, logic [2:0] s, logic [7:0] d);
    en = e; mode = m; iv = v; sel = s; dw = d;
    @(posedge clk);
    mstep(0);
    mstep(1);
    @(negedge clk);
    chk("y0", y0, ey(0));
    chk("y1", y1, ey(1));
    chk("valid0", 8'(v0), 8'(on[0]));
    chk("valid1", 8'(v1), 8'(on[1]));
    chk("ready0", 8'(r0), 8'(eng[0] == 0 && blank[0] < 0));
    chk("ready1", 8'(r1), 8'(eng[1] == 0 && blank[1] < 0));
    chk("cur0", 8'(c0), 8'(code[0]));
    chk("cur1", 8'(c1), 8'(code[1]));
    chk("wrap0", 8'(w0), 8'(wr[0]));
    chk("wrap1", 8'(w1), 8'(wr[1]));
    chk("onehot0", 8'($countones(y0) <= 1), 8'd1);
    chk("onehot1", 8'($countones(~y1) <= 1), 8'd1);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 3'd0, 8'd0, 8'h00, 0, 1, 3'd0};
    tbl[1]  = '{1, 0, 1, 3'd3, 8'd0, 8'h08, 1, 1, 3'd3};
    tbl[2]  = '{1, 0, 1, 3'd5, 8'd0, 8'h20, 1, 1, 3'd5};
    tbl[3]  = '{1, 0, 0, 3'd0, 8'd0, 8'h20, 1, 1, 3'd5};
    tbl[4]  = '{1, 1, 0, 3'd0, 8'd0, 8'h00, 0, 0, 3'd5};
    tbl[5]  = '{1, 1, 0, 3'd0, 8'd0, 8'h01, 1, 0, 3'd0};
    tbl[6]  = '{1, 1, 1, 3'd6, 8'd0, 8'h02, 1, 0, 3'd1};
    tbl[7]  = '{1, 1, 1, 3'd6, 8'd0, 8'h04, 1, 0, 3'd2};
    tbl[8]  = '{1, 1, 0, 3'd0, 8'd0, 8'h08, 1, 0, 3'd3};
    tbl[9]  = '{1, 1, 0, 3'd0, 8'd0, 8'h10, 1, 0, 3'd4};
    tbl[10] = '{1, 0, 0, 3'd0, 8'd0, 8'h00, 0, 0, 3'd4};
    tbl[11] = '{1, 0, 0, 3'd0, 8'd0, 8'h00, 0, 1, 3'd4};
    tbl[12] = '{1, 0, 1, 3'd2, 8'd0, 8'h04, 1, 1, 3'd2};
    tbl[13] = '{0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 0, 3'd2};
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_y0", y0, 8'h00);
    chk("rst_y1", y1, 8'hFF);
    chk("rst_valid0", 8'(v0), 8'd0);
    chk("rst_ready0", 8'(r0), 8'd0);
    chk("rst_wrap0", 8'(w0), 8'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      cyc(tbl[k].e, tbl[k].m, tbl[k].v, tbl[k].s, tbl[k].d);
      chk($sformatf("tbl%0d_y", k), y0, tbl[k].y);
      chk($sformatf("tbl%0d_valid", k), 8'(v0), 8'(tbl[k].val));
      chk($sformatf("tbl%0d_ready", k), 8'(r0), 8'(tbl[k].rdy));
      chk($sformatf("tbl%0d_cur", k), 8'(c0), 8'(tbl[k].cs));
    end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 3, 0);
    chk("bbm_first", y1, 8'hF7);
    cyc(1, 0, 1, 6, 0);
    chk("bbm_gap_y", y1, 8'hFF);
    chk("bbm_gap_ready", 8'(r1), 8'd0);
    cyc(1, 0, 1, 1, 0);
    chk("bbm_new", y1, 8'hBF);
    chk("bbm_new_cur", 8'(c1), 8'd6);
    cyc(1, 0, 1, 6, 0);
    chk("bbm_same", y1, 8'hBF);
    chk("bbm_same_ready", 8'(r1), 8'd1);
    cyc(0, 0, 0, 0, 0);
    for (int t = 0; t <= 24; t++) begin
      cyc(1, 1, 0, 0, 2);
      chk($sformatf("dw2_y_t%0d", t), y0, 8'(1 << ((t / 3) % 8)));
      chk($sformatf("dw2_wrap_t%0d", t), 8'(w0), 8'(t == 24));
    end
    for (int t = 1; t <= 16; t++) begin
      cyc(1, 1, 1, 3'(t), 0);
      chk($sformatf("dw0_y_t%0d", t), y0, 8'(1 << (t % 8)));
      chk($sformatf("dw0_wrap_t%0d", t), 8'(w0), 8'(t % 8 == 0));
      chk($sformatf("dw0_ready_t%0d", t), 8'(r0), 8'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y0", y0, 8'h00);
    chk("arst_y1", y1, 8'hFF);
    chk("arst_valid0", 8'(v0), 8'd0);
    chk("arst_valid1", 8'(v1), 8'd0);
    chk("arst_wrap0", 8'(w0), 8'd0);
    chk("arst_cur0", 8'(c0), 8'd0);
    @(negedge clk);
    mreset();
    chk("arst_hold_y0", y0, 8'h00);
    rst_n = 1'b1;
    begin
      bit m = 1'b1;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 15) == 0) m = ~m;
        cyc($urandom_range(0, 15) != 0, m, 1'($urandom), 3'($urandom), 8'($urandom_range(0, 3)));
      end
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
